// File: rtl/rapids_fetch_pkg.sv
// Shared definitions for the rapids instruction fetch path: FSM state
// encoding, instruction size and address-space defaults.
package rapids_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES       = 4;
  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] MEM_LIMIT_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a word fetch address; also reused by the
// data-side segfault logic.
module fetch_addr_check (
  input  logic [31:0] addr,
  input  logic [31:0] limit,
  output logic        fault
);

  assign fault = (addr[1:0] != 2'b00) || (addr >= limit);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads over req/ack and holds the
// returned instruction for the control path.
module instruction_fetch
  import rapids_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] MEM_LIMIT = MEM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        wait_instr,
  output logic        instr_segv,
  output logic [31:0] pc,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] HOLD  = ST_HOLD;
  localparam logic [1:0] FAULT = ST_FAULT;

  // Handshake: imem_req/imem_addr are held stable from FETCH entry until the
  // edge that samples imem_ack=1; imem_ack is ignored while imem_req=0.
  logic [1:0]  state_next;
  logic [31:0] pc_next;
  logic        redir_pend;
  logic [31:0] redir_target;
  logic        fetch_fault;
  logic        redirect_now;

  assign redirect_now = redir_pend || pc_load;

  always_comb begin
    pc_next = pc;
    case (state)
      FETCH: if (imem_ack && redirect_now) pc_next = pc_load ? pc_target : redir_target;
      HOLD: begin
        if (pc_load)     pc_next = pc_target;
        else if (pc_inc) pc_next = pc + 32'(INSTR_BYTES);
      end
      default: pc_next = pc;
    endcase
  end

  // The legality check always looks at the address the next FETCH would use.
  fetch_addr_check u_addr_check (
    .addr  (pc_next),
    .limit (MEM_LIMIT),
    .fault (fetch_fault)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (go) state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (!go)               state_next = IDLE;
          else if (redirect_now) state_next = FETCH;
          else                   state_next = HOLD;
        end
      end
      HOLD: begin
        if (!go)                    state_next = IDLE;
        else if (pc_load || pc_inc) state_next = FETCH;
      end
      default: state_next = FAULT;
    endcase
    if (state_next == FETCH && state != FETCH && fetch_fault) state_next = FAULT;
    if (state == FETCH && imem_ack && state_next == FETCH && fetch_fault) state_next = FAULT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pc           <= PC_RESET;
      instruction  <= '0;
      imem_req     <= 1'b0;
      redir_pend   <= 1'b0;
      redir_target <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      imem_req <= (state_next == FETCH);
      if (state == FETCH) begin
        if (imem_ack) begin
          redir_pend <= 1'b0;
        end else if (pc_load) begin
          redir_pend   <= 1'b1;
          redir_target <= pc_target;
        end
        // A redirected or abandoned transaction completes but its data is dropped.
        if (imem_ack && !redirect_now && go) instruction <= imem_rdata;
      end
    end
  end

  assign imem_addr  = pc;
  assign wait_instr = (state != HOLD);
  assign instr_segv = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a wait-state memory model and a
// monitor for requests to illegal addresses.
module tb_instruction_fetch;
  import rapids_fetch_pkg::*;

  logic        clk;
  logic        resetn;
  logic        go;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        wait_instr;
  logic        instr_segv;
  logic [31:0] pc;
  logic [1:0]  state;

  int n_cmp;
  int n_err;
  int mem_wait;
  int mem_cnt;
  logic bad_seen;

  instruction_fetch dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .wait_instr (wait_instr),
    .instr_segv (instr_segv),
    .pc         (pc),
    .state      (state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hDEAD_BEEF : (32'hA500_0000 | a);
  endfunction

  // Memory model: acks after mem_wait idle FETCH cycles, on the negedge.
  always @(negedge clk) begin
    if (imem_req) begin
      if (mem_cnt == mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
        mem_cnt    = mem_cnt + 1;
      end
      if (imem_addr[1:0] != 2'b00 || imem_addr >= 32'h0001_0000) bad_seen = 1'b1;
    end else begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    go = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_wait", {31'b0, wait_instr}, 32'd1);
    check("rst_segv", {31'b0, instr_segv}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_state", {30'b0, state}, 32'(ST_IDLE));
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mem_wait = 0; mem_cnt = 0; bad_seen = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    resetn = 1'b1; go = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; pc_target = 32'h0;

    // Zero-wait fetch of address 0, then increment.
    do_reset();
    go = 1'b1;
    tick();
    check("t1_req", {31'b0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_wait_fetch", {31'b0, wait_instr}, 32'd1);
    tick();
    check("t1_instr", instruction, 32'hDEAD_BEEF);
    check("t1_wait_hold", {31'b0, wait_instr}, 32'd0);
    check("t1_req_hold", {31'b0, imem_req}, 32'd0);
    mem_wait = 3;
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("t1_addr_inc", imem_addr, 32'h4);

    // Three wait cycles: address and wait_instr stable for four cycles.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check($sformatf("t2_addr_%0d", i), imem_addr, 32'h4);
      check($sformatf("t2_req_%0d", i), {31'b0, imem_req}, 32'd1);
      check($sformatf("t2_wait_%0d", i), {31'b0, wait_instr}, 32'd1);
    end
    tick();
    check("t2_instr", instruction, 32'hA500_0004);
    check("t2_wait", {31'b0, wait_instr}, 32'd0);

    // Redirect during FETCH at PC 8.
    mem_wait = 1;
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("t3_addr8", imem_addr, 32'h8);
    pc_load = 1'b1; pc_target = 32'h100;
    tick();
    pc_load = 1'b0;
    check("t3_still8", imem_addr, 32'h8);
    tick();
    check("t3_addr100", imem_addr, 32'h100);
    check("t3_req100", {31'b0, imem_req}, 32'd1);
    check("t3_discard", instruction, 32'hA500_0004);
    tick();
    tick();
    check("t3_instr100", instruction, 32'hA500_0100);
    check("t3_wait", {31'b0, wait_instr}, 32'd0);

    // pc_inc and pc_load together: load wins.
    mem_wait = 0;
    pc_inc = 1'b1; pc_load = 1'b1; pc_target = 32'h40;
    tick();
    pc_inc = 1'b0; pc_load = 1'b0;
    check("t4_addr", imem_addr, 32'h40);
    check("t4_pc", pc, 32'h40);
    tick();
    check("t4_instr", instruction, 32'hA500_0040);

    // Redirect beyond the address space faults and sticks.
    pc_load = 1'b1; pc_target = 32'h0001_0000;
    tick();
    pc_load = 1'b0;
    check("t5_segv", {31'b0, instr_segv}, 32'd1);
    check("t5_req", {31'b0, imem_req}, 32'd0);
    check("t5_wait", {31'b0, wait_instr}, 32'd1);
    pc_inc = 1'b1;
    tick(); tick(); tick();
    pc_inc = 1'b0;
    check("t5_sticky", {31'b0, instr_segv}, 32'd1);
    check("t5_state", {30'b0, state}, 32'(ST_FAULT));
    check("t5_req_sticky", {31'b0, imem_req}, 32'd0);
    do_reset();
    check("t5_cleared", {31'b0, instr_segv}, 32'd0);

    // Misaligned redirect target.
    go = 1'b1;
    tick(); tick();
    check("t5b_instr", instruction, 32'hDEAD_BEEF);
    pc_load = 1'b1; pc_target = 32'h6;
    tick();
    pc_load = 1'b0;
    check("t5b_segv", {31'b0, instr_segv}, 32'd1);
    check("t5b_req", {31'b0, imem_req}, 32'd0);
    tick(); tick();
    check("t5b_sticky", {31'b0, instr_segv}, 32'd1);
    do_reset();

    // go dropped during FETCH at PC 12: data discarded, refetch on resume.
    mem_wait = 1;
    go = 1'b1;
    tick(); tick(); tick();
    check("t6_instr0", instruction, 32'hDEAD_BEEF);
    pc_load = 1'b1; pc_target = 32'hC;
    tick();
    pc_load = 1'b0;
    check("t6_addr12", imem_addr, 32'hC);
    go = 1'b0;
    tick();
    check("t6_req_pending", {31'b0, imem_req}, 32'd1);
    tick();
    check("t6_idle", {30'b0, state}, 32'(ST_IDLE));
    check("t6_req_off", {31'b0, imem_req}, 32'd0);
    check("t6_pc", pc, 32'hC);
    check("t6_discard", instruction, 32'hDEAD_BEEF);
    check("t6_wait", {31'b0, wait_instr}, 32'd1);
    go = 1'b1;
    tick();
    check("t6_refetch", imem_addr, 32'hC);
    check("t6_refetch_req", {31'b0, imem_req}, 32'd1);
    tick(); tick();
    check("t6_instr12", instruction, 32'hA500_000C);
    check("t6_wait_hold", {31'b0, wait_instr}, 32'd0);

    check("no_bad_request", {31'b0, bad_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the rapids core. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It registers the returned word and presents it to the control path as `instruction`, with `wait_instr` and `instr_segv` status. It sits directly upstream of the control path: it consumes that block's `pc_inc` and branch redirect, and it produces the instruction word and fetch-fault indication.

## Interface
- `PC_RESET`, 32'h0000_0000: PC value after reset.
- `MEM_LIMIT`, 32'h0001_0000: exclusive upper bound of the legal instruction address space.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `go` in 1: run enable; low halts fetching.
- `pc_inc` in 1: control path has consumed `instruction`; advance PC by 4.
- `pc_load` in 1: redirect; load `pc_target` into PC.
- `pc_target` in 32: redirect target address.
- `imem_req` out 1: read request, registered.
- `imem_addr` out 32: read address; equals `pc`.
- `imem_ack` in 1: read data valid; sampled only while `imem_req`=1.
- `imem_rdata` in 32: read data.
- `instruction` out 32: registered instruction word.
- `wait_instr` out 1: 1 whenever `instruction` is not valid for the current PC.
- `instr_segv` out 1: fetch fault, sticky.
- `pc` out 32: current program counter.

## Operation
States:
- **IDLE**: no request issued; PC is retained.
- **FETCH**: `imem_req`=1.
- **HOLD**: instruction valid; `wait_instr`=0 only in this state.
- **FAULT**: terminal.

Transitions:
- IDLE -> FETCH when `go`=1.
- FETCH -> HOLD on `imem_ack`. The word is captured into `instruction` on the same edge.
- HOLD -> FETCH on `pc_inc` or `pc_load`. The PC is updated on the same edge.
- HOLD -> IDLE when `go`=0.

PC update rules:
- `pc_load` has priority over `pc_inc`.
- `pc_inc`: PC <= PC + 4, mod 2^32.

Address check, evaluated on the PC that is about to be fetched:
- A fault occurs if `pc[1:0]` != 0 or `pc` >= `MEM_LIMIT`.
- On a fault, go to FAULT instead of FETCH. No request is issued for the bad address.
- In FAULT: `instr_segv`=1, `wait_instr`=1, `imem_req`=0. Only `resetn` leaves FAULT.

Redirect during FETCH:
- `pc_load` in FETCH sets a pending-redirect flag and latches the target.
- The outstanding transaction still completes. Its data is discarded when `imem_ack` arrives.
- The PC is then set to the target and a new FETCH begins after the address check.
- `pc_inc` in FETCH is ignored.

`go`=0 during FETCH:
- The transaction completes and its data is discarded.
- The next state is IDLE and the PC is unchanged, so the same address is refetched on resume.

Reset values:
- `pc`=`PC_RESET`.
- `instruction`=0.
- `imem_req`=0.
- `wait_instr`=1.
- `instr_segv`=0.
- State = IDLE; pending-redirect flag = 0.

## Timing
- `imem_req` and `imem_addr` are registered. They are asserted on the edge entering FETCH and stay stable until the edge on which `imem_ack`=1 is sampled.
- Zero-wait memory (ack in the first FETCH cycle) gives `wait_instr`=0 one cycle after FETCH entry. Each memory wait cycle adds one cycle.
- Fetch throughput is one instruction per 2 cycles at best: HOLD -> FETCH -> HOLD.
- `wait_instr` and `instr_segv` are decoded from the registered state only. There are no combinational paths from inputs to outputs.
- `pc_inc` and `pc_load` arriving in the same cycle: load wins and the increment is dropped.
- A redirect to an illegal target enters FAULT one cycle after the load. The bad address never appears on `imem_addr` with `imem_req`=1.
- `resetn` asserted mid-transaction clears `imem_req` asynchronously. The memory side must tolerate an abandoned request.

## Structure
- Shared package `rapids_fetch_pkg` holds:
  - the state enum (IDLE, FETCH, HOLD, FAULT);
  - `INSTR_BYTES` = 4;
  - the defaults for `PC_RESET` and `MEM_LIMIT`.
- One combinational sub-module, `fetch_addr_check` (addr, limit -> fault), is shared with the data-side segfault logic.
- PC next-value logic and the FSM live in the top module.

## Test plan
- Reset, then `go`=1 with zero-wait memory returning 32'hDEAD_BEEF at address 0. `imem_req` rises 1 cycle after `go`, `instruction`=32'hDEAD_BEEF, and `wait_instr`=0 the cycle after ack. Pulsing `pc_inc` then gives `imem_addr`=4.
- Memory acks after 3 wait cycles. `imem_addr` stays stable for 4 cycles and `wait_instr` stays 1 throughout.
- `pc_load`=1 with `pc_target`=32'h100 while in FETCH at PC 8. Data for 8 is discarded and the next request is at 32'h100.
- `pc_inc`=1 and `pc_load`=1 (target 32'h40) in the same cycle. The next `imem_addr` is 32'h40.
- `pc_load` with target 32'h0001_0000, and separately target 32'h6. `instr_segv`=1 the next cycle, `imem_req` is never asserted for the bad address, and the fault persists until `resetn`.
- `go` dropped during FETCH at PC 12. The ack is discarded, the block goes to IDLE, and when `go` rises again it refetches 12.
